// File: rtl/imem_access_arbiter_if.sv
// Fetch, debug-burst and instruction-memory signals that cross the arbiter boundary.
// slave = arbiter side, master = requesters plus memory side.
interface imem_access_arbiter_if;
   logic        fetch_req;
   logic [31:0] fetch_addr;
   logic        fetch_gnt;
   logic        fetch_vld;
   logic [31:0] fetch_dat;
   logic        fetch_err;
   logic        dbg_start;
   logic [31:0] dbg_addr;
   logic [4:0]  dbg_len;
   logic        dbg_busy;
   logic        dbg_vld;
   logic [31:0] dbg_dat;
   logic        dbg_done;
   logic        dbg_err;
   logic [31:0] mem_address;
   logic [31:0] mem_instruction;

   modport slave (
      input  fetch_req, fetch_addr, dbg_start, dbg_addr, dbg_len, mem_instruction,
      output fetch_gnt, fetch_vld, fetch_dat, fetch_err,
      output dbg_busy, dbg_vld, dbg_dat, dbg_done, dbg_err, mem_address
   );

   modport master (
      output fetch_req, fetch_addr, dbg_start, dbg_addr, dbg_len, mem_instruction,
      input  fetch_gnt, fetch_vld, fetch_dat, fetch_err,
      input  dbg_busy, dbg_vld, dbg_dat, dbg_done, dbg_err, mem_address
   );
endinterface

// File: rtl/imem_access_arbiter.sv
// Shares the instruction memory's single read port between fetch and debug bursts.
// Latency: grant in cycle N, registered response in N+1; fetch waits at most one cycle per conflict.
module imem_access_arbiter #(
   parameter int WORDS  = 128,
   parameter int MAXLEN = 16
) (
   input logic                   i_clk,
   input logic                   i_rst_n,
   imem_access_arbiter_if.slave  io_bus
);
   localparam int AW = $clog2(WORDS);

   typedef enum logic {ST_IDLE, ST_BURST} state_t;
   typedef enum logic {WIN_FETCH, WIN_DEBUG} win_t;

   state_t      r_state, w_state_nxt;
   win_t        r_last_win, w_last_win_nxt;
   logic [AW-1:0] r_ptr, w_ptr_nxt;
   logic [4:0]  r_remaining, w_remaining_nxt;
   logic        r_fetch_vld, r_fetch_err, r_dbg_busy, r_dbg_vld, r_dbg_done, r_dbg_err;
   logic [31:0] r_fetch_dat, r_dbg_dat;

   logic        w_fetch_win, w_dbg_win, w_start_bad;
   logic        w_fetch_legal, w_start_ok;
   logic [31:0] w_mem_address;

   assign w_fetch_legal = (io_bus.fetch_addr[1:0] == 2'b00) &&
                          (io_bus.fetch_addr[31:AW+2] == '0);
   assign w_start_ok    = (io_bus.dbg_addr[1:0] == 2'b00) &&
                          (io_bus.dbg_addr[31:AW+2] == '0) &&
                          (io_bus.dbg_len != 5'd0) && (io_bus.dbg_len <= 5'(MAXLEN));

   always_comb begin
      w_state_nxt     = r_state;
      w_last_win_nxt  = r_last_win;
      w_ptr_nxt       = r_ptr;
      w_remaining_nxt = r_remaining;
      w_fetch_win     = 1'b0;
      w_dbg_win       = 1'b0;
      w_start_bad     = 1'b0;
      w_mem_address   = '0;
      case (r_state)
         ST_IDLE: begin
            w_fetch_win = io_bus.fetch_req;
            if (io_bus.dbg_start) begin
               if (w_start_ok) begin
                  w_state_nxt     = ST_BURST;
                  w_ptr_nxt       = io_bus.dbg_addr[AW+1:2];
                  w_remaining_nxt = io_bus.dbg_len;
               end else begin
                  w_start_bad = 1'b1;
               end
            end
         end
         ST_BURST: begin
            // On a conflict the side that lost last time wins this time.
            if (io_bus.fetch_req) begin
               w_fetch_win    = (r_last_win == WIN_DEBUG);
               w_dbg_win      = (r_last_win == WIN_FETCH);
               w_last_win_nxt = (r_last_win == WIN_DEBUG) ? WIN_FETCH : WIN_DEBUG;
            end else begin
               w_dbg_win = 1'b1;
            end
            if (w_dbg_win) begin
               w_ptr_nxt       = r_ptr + 1'b1;
               w_remaining_nxt = r_remaining - 5'd1;
               if (r_remaining == 5'd1) w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      if (w_fetch_win)
         w_mem_address = {{(30-AW){1'b0}}, io_bus.fetch_addr[AW+1:2], 2'b00};
      else if (w_dbg_win)
         w_mem_address = {{(30-AW){1'b0}}, r_ptr, 2'b00};
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_last_win  <= WIN_DEBUG;
         r_ptr       <= '0;
         r_remaining <= '0;
         r_fetch_vld <= 1'b0;
         r_fetch_dat <= '0;
         r_fetch_err <= 1'b0;
         r_dbg_busy  <= 1'b0;
         r_dbg_vld   <= 1'b0;
         r_dbg_dat   <= '0;
         r_dbg_done  <= 1'b0;
         r_dbg_err   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_last_win  <= w_last_win_nxt;
         r_ptr       <= w_ptr_nxt;
         r_remaining <= w_remaining_nxt;
         r_fetch_vld <= w_fetch_win;
         // Illegal fetches are still granted but return zero data with an error flag.
         r_fetch_dat <= (w_fetch_win && w_fetch_legal) ? io_bus.mem_instruction : '0;
         r_fetch_err <= w_fetch_win && !w_fetch_legal;
         r_dbg_busy  <= (w_state_nxt == ST_BURST);
         r_dbg_vld   <= w_dbg_win;
         r_dbg_dat   <= w_dbg_win ? io_bus.mem_instruction : '0;
         r_dbg_done  <= w_dbg_win && (r_remaining == 5'd1);
         r_dbg_err   <= w_start_bad;
      end
   end

   assign io_bus.fetch_gnt   = w_fetch_win;
   assign io_bus.mem_address = w_mem_address;
   assign io_bus.fetch_vld   = r_fetch_vld;
   assign io_bus.fetch_dat   = r_fetch_dat;
   assign io_bus.fetch_err   = r_fetch_err;
   assign io_bus.dbg_busy    = r_dbg_busy;
   assign io_bus.dbg_vld     = r_dbg_vld;
   assign io_bus.dbg_dat     = r_dbg_dat;
   assign io_bus.dbg_done    = r_dbg_done;
   assign io_bus.dbg_err     = r_dbg_err;
endmodule

// File: tb/tb_imem_access_arbiter.sv
// Directed bench for imem_access_arbiter: memory model holds word i = i*3.
module tb_imem_access_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;
   logic [31:0] mem [128];

   imem_access_arbiter_if bus();

   imem_access_arbiter dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_bus  (bus)
   );

   always #5 clk = ~clk;

   assign bus.mem_instruction = mem[bus.mem_address[8:2]];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_fvld"}, 32'(bus.fetch_vld), 32'd0);
      chk({tag, "_fdat"}, bus.fetch_dat, 32'd0);
      chk({tag, "_ferr"}, 32'(bus.fetch_err), 32'd0);
      chk({tag, "_busy"}, 32'(bus.dbg_busy), 32'd0);
      chk({tag, "_dvld"}, 32'(bus.dbg_vld), 32'd0);
      chk({tag, "_ddat"}, bus.dbg_dat, 32'd0);
      chk({tag, "_done"}, 32'(bus.dbg_done), 32'd0);
      chk({tag, "_derr"}, 32'(bus.dbg_err), 32'd0);
   endtask

   task automatic start_burst(input logic [31:0] addr, input logic [4:0] len);
      bus.dbg_start = 1'b1;
      bus.dbg_addr  = addr;
      bus.dbg_len   = len;
      tick();
      bus.dbg_start = 1'b0;
   endtask

   initial begin
      logic [31:0] wrap_exp [4];
      logic [31:0] rej_exp [3];
      logic        exp_gnt [7];
      wrap_exp = '{32'd378, 32'd381, 32'd0, 32'd3};
      rej_exp  = '{32'd24, 32'd27, 32'd30};
      exp_gnt  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 128; i++) mem[i] = 32'(i * 3);
      bus.fetch_req  = 1'b0;
      bus.fetch_addr = '0;
      bus.dbg_start  = 1'b0;
      bus.dbg_addr   = '0;
      bus.dbg_len    = '0;

      // Reset state
      tick();
      tick();
      chk_idle_outputs("rst");
      chk("rst_maddr", bus.mem_address, 32'd0);
      #2 rst_n = 1'b1;
      tick();

      // Fetch only
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h0C;
      #1;
      chk("f_gnt", 32'(bus.fetch_gnt), 32'd1);
      chk("f_maddr", bus.mem_address, 32'h0C);
      tick();
      bus.fetch_req = 1'b0;
      chk("f_vld", 32'(bus.fetch_vld), 32'd1);
      chk("f_dat", bus.fetch_dat, 32'd9);
      chk("f_err", 32'(bus.fetch_err), 32'd0);
      tick();
      chk("f_vld_pulse", 32'(bus.fetch_vld), 32'd0);

      // Illegal fetches: misaligned then out of range
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h0E;
      #1;
      chk("ill0_gnt", 32'(bus.fetch_gnt), 32'd1);
      tick();
      bus.fetch_addr = 32'h400;
      chk("ill0_vld", 32'(bus.fetch_vld), 32'd1);
      chk("ill0_err", 32'(bus.fetch_err), 32'd1);
      chk("ill0_dat", bus.fetch_dat, 32'd0);
      #1;
      chk("ill1_gnt", 32'(bus.fetch_gnt), 32'd1);
      tick();
      bus.fetch_req = 1'b0;
      chk("ill1_vld", 32'(bus.fetch_vld), 32'd1);
      chk("ill1_err", 32'(bus.fetch_err), 32'd1);
      chk("ill1_dat", bus.fetch_dat, 32'd0);
      tick();

      // Burst wrapping from word 126
      start_burst(32'h1F8, 5'd4);
      #1;
      chk("w_maddr0", bus.mem_address, 32'h1F8);
      #1;
      for (int k = 1; k <= 5; k++) begin
         if (k > 1) tick();
         chk($sformatf("w_busy%0d", k), 32'(bus.dbg_busy), 32'(k <= 4));
         chk($sformatf("w_vld%0d", k), 32'(bus.dbg_vld), 32'(k >= 2));
         chk($sformatf("w_done%0d", k), 32'(bus.dbg_done), 32'(k == 5));
         if (k >= 2) chk($sformatf("w_dat%0d", k), bus.dbg_dat, wrap_exp[k-2]);
      end
      tick();
      chk("w_vld_end", 32'(bus.dbg_vld), 32'd0);

      // Contention after a fresh reset: fetch wins the first conflict
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      tick();
      start_burst(32'h0, 5'd3);
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h10;
      for (int k = 1; k <= 7; k++) begin
         if (k > 1) tick();
         #1;
         if (k <= 6) chk($sformatf("c_gnt%0d", k), 32'(bus.fetch_gnt), 32'(exp_gnt[k]));
         chk($sformatf("c_fvld%0d", k), 32'(bus.fetch_vld), 32'(k == 2 || k == 4 || k == 6));
         if (k == 2 || k == 4 || k == 6) chk($sformatf("c_fdat%0d", k), bus.fetch_dat, 32'd12);
         chk($sformatf("c_dvld%0d", k), 32'(bus.dbg_vld), 32'(k == 3 || k == 5 || k == 7));
         if (k == 3 || k == 5 || k == 7) chk($sformatf("c_ddat%0d", k), bus.dbg_dat, 32'((k - 3) / 2 * 3));
         chk($sformatf("c_done%0d", k), 32'(bus.dbg_done), 32'(k == 7));
      end
      bus.fetch_req = 1'b0;
      tick();

      // Rejected starts
      start_burst(32'h0, 5'd0);
      chk("rj_len_err", 32'(bus.dbg_err), 32'd1);
      chk("rj_len_busy", 32'(bus.dbg_busy), 32'd0);
      tick();
      chk("rj_err_pulse", 32'(bus.dbg_err), 32'd0);
      start_burst(32'h2, 5'd1);
      chk("rj_addr_err", 32'(bus.dbg_err), 32'd1);
      chk("rj_addr_busy", 32'(bus.dbg_busy), 32'd0);
      start_burst(32'h20, 5'd3);
      chk("rj_err_ok", 32'(bus.dbg_err), 32'd0);
      start_burst(32'h40, 5'd1);
      for (int k = 0; k < 3; k++) begin
         if (k > 0) tick();
         chk($sformatf("rj_derr%0d", k), 32'(bus.dbg_err), 32'd0);
         chk($sformatf("rj_vld%0d", k), 32'(bus.dbg_vld), 32'd1);
         chk($sformatf("rj_dat%0d", k), bus.dbg_dat, rej_exp[k]);
         chk($sformatf("rj_done%0d", k), 32'(bus.dbg_done), 32'(k == 2));
      end
      tick();
      chk("rj_busy_end", 32'(bus.dbg_busy), 32'd0);

      // Reset in the middle of an 8-word burst
      start_burst(32'h0, 5'd8);
      tick();
      chk("mr_dat0", bus.dbg_dat, 32'd0);
      tick();
      chk("mr_dat1", bus.dbg_dat, 32'd3);
      #2 rst_n = 1'b0;
      #1;
      chk_idle_outputs("mr");
      tick();
      tick();
      chk("mr_held_vld", 32'(bus.dbg_vld), 32'd0);
      #2 rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("mr_post_vld%0d", k), 32'(bus.dbg_vld), 32'd0);
         chk($sformatf("mr_post_done%0d", k), 32'(bus.dbg_done), 32'd0);
         chk($sformatf("mr_post_maddr%0d", k), bus.mem_address, 32'd0);
      end
      start_burst(32'h8, 5'd2);
      chk("nb_busy", 32'(bus.dbg_busy), 32'd1);
      tick();
      chk("nb_dat0", bus.dbg_dat, 32'd6);
      chk("nb_done0", 32'(bus.dbg_done), 32'd0);
      tick();
      chk("nb_dat1", bus.dbg_dat, 32'd9);
      chk("nb_done1", 32'(bus.dbg_done), 32'd1);
      tick();
      chk("nb_busy_end", 32'(bus.dbg_busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
